// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back stage:
//   LS_BYTE / LS_HALF / LS_WORD : load_size encodings (2'b11 also means word)
//   ZERO_REG                    : architectural zero register, never written
//   ls_is_word()                : true for both word encodings (10 and 11)
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam logic [1:0] LS_BYTE  = 2'b00;
   localparam logic [1:0] LS_HALF  = 2'b01;
   localparam logic [1:0] LS_WORD  = 2'b10;

   localparam logic [4:0] ZERO_REG = 5'd0;

   // Both 2'b10 and 2'b11 select a full word, so only the upper bit matters.
   function automatic logic ls_is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational little-endian load extraction and extension.
// Ports:
//   rdata       in  32  raw memory word
//   addr_lo     in   2  byte offset inside the word
//   size        in   2  load size (LS_BYTE, LS_HALF, word)
//   is_unsigned in   1  1 = zero-extend, 0 = sign-extend byte/half
//   data        out 32  aligned, extended load result
// Misaligned half/word accesses are not flagged here; the stage handles that.
// -----------------------------------------------------------------------------
module load_align
   import wb_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        byte_sign;
   logic        half_sign;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
   end

   // Half selection only uses the upper offset bit; an odd offset is a
   // misalignment and is suppressed by the stage, not corrected here.
   assign half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   assign byte_sign = ~is_unsigned & byte_sel[7];
   assign half_sign = ~is_unsigned & half_sel[15];

   always_comb begin
      data = rdata;
      if (!ls_is_word(size)) begin
         if (size == LS_BYTE)
            data = {{24{byte_sign}}, byte_sel};
         else
            data = {{16{half_sign}}, half_sel};
      end
   end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Final pipeline stage: registers the MEM result, aligns load data and drives
// the register-file write port (the regfile samples on the falling edge).
// Parameters:
//   CNT_W          width of retire counter
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid       in   MEM result valid
//   in_ready       out  stage accepts (= !stall)
//   stall, flush   in   hold stage / kill held entry (flush wins)
//   alu_res        in   32-bit ALU result
//   mem_rdata      in   32-bit raw memory word
//   mem_addr_lo    in   byte offset of the load
//   load_size      in   00 byte, 01 half, 10/11 word
//   load_unsigned  in   zero-extend byte/half loads
//   mem_to_reg     in   select load data instead of ALU result
//   reg_write      in   instruction writes a register
//   dst_reg        in   destination register number
//   RegWrite       out  regfile write enable
//   WbRegNum       out  regfile write address
//   WbData         out  regfile write data
//   wb_valid       out  stage holds a valid entry
//   misalign       out  current retiring load is misaligned (write dropped)
//   retire_cnt     out  retired-entry counter
// Configuration macro:
//   WB_RETIRE_CNT_EN  when defined, retire_cnt counts every fired entry
//                     (wraps); when undefined, retire_cnt is tied to zero.
// -----------------------------------------------------------------------------
module wb_stage
   import wb_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      alu_res,
   input  logic [31:0]      mem_rdata,
   input  logic [1:0]       mem_addr_lo,
   input  logic [1:0]       load_size,
   input  logic             load_unsigned,
   input  logic             mem_to_reg,
   input  logic             reg_write,
   input  logic [4:0]       dst_reg,
   output logic             RegWrite,
   output logic [4:0]       WbRegNum,
   output logic [31:0]      WbData,
   output logic             wb_valid,
   output logic             misalign,
   output logic [CNT_W-1:0] retire_cnt
);

   logic        valid_q;
   logic [31:0] alu_res_q;
   logic [31:0] mem_rdata_q;
   logic [1:0]  addr_lo_q;
   logic [1:0]  load_size_q;
   logic        load_unsigned_q;
   logic        mem_to_reg_q;
   logic        reg_write_q;
   logic [4:0]  dst_reg_q;

   logic        fire;
   logic        bad_align;
   logic [31:0] load_data;

   assign in_ready = !stall;

   // Data fields are all cleared by reset so WbData/WbRegNum read zero
   // while reset is asserted. A flush only kills the valid bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q         <= 1'b0;
         alu_res_q       <= '0;
         mem_rdata_q     <= '0;
         addr_lo_q       <= '0;
         load_size_q     <= '0;
         load_unsigned_q <= 1'b0;
         mem_to_reg_q    <= 1'b0;
         reg_write_q     <= 1'b0;
         dst_reg_q       <= '0;
      end else if (flush) begin
         valid_q         <= 1'b0;
      end else if (!stall) begin
         valid_q         <= in_valid;
         alu_res_q       <= alu_res;
         mem_rdata_q     <= mem_rdata;
         addr_lo_q       <= mem_addr_lo;
         load_size_q     <= load_size;
         load_unsigned_q <= load_unsigned;
         mem_to_reg_q    <= mem_to_reg;
         reg_write_q     <= reg_write;
         dst_reg_q       <= dst_reg;
      end
   end

   load_align u_load_align (
      .rdata       (mem_rdata_q),
      .addr_lo     (addr_lo_q),
      .size        (load_size_q),
      .is_unsigned (load_unsigned_q),
      .data        (load_data)
   );

   // An entry retires in the one cycle it is valid and not stalled; the next
   // edge replaces it, so the write cannot repeat.
   assign fire      = valid_q && !stall;

   assign bad_align = ((load_size_q == LS_HALF) && addr_lo_q[0]) ||
                      (ls_is_word(load_size_q) && (addr_lo_q != 2'b00));

   assign misalign  = fire && mem_to_reg_q && bad_align;

   assign RegWrite  = fire && reg_write_q && (dst_reg_q != ZERO_REG) && !misalign;
   assign WbRegNum  = dst_reg_q;
   assign WbData    = mem_to_reg_q ? load_data : alu_res_q;
   assign wb_valid  = valid_q;

`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] retire_cnt_q;

   // Counts every retired entry, including misaligned and non-writing ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         retire_cnt_q <= '0;
      else if (fire)
         retire_cnt_q <= retire_cnt_q + CNT_W'(1);
   end

   assign retire_cnt = retire_cnt_q;
`else
   assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
`timescale 1ns/1ps
module tb_wb_stage;

`ifdef WB_RETIRE_CNT_EN
   localparam int TB_CNT_W = 4;
`else
   localparam int TB_CNT_W = 32;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic                stall;
   logic                flush;
   logic [31:0]         alu_res;
   logic [31:0]         mem_rdata;
   logic [1:0]          mem_addr_lo;
   logic [1:0]          load_size;
   logic                load_unsigned;
   logic                mem_to_reg;
   logic                reg_write;
   logic [4:0]          dst_reg;
   logic                RegWrite;
   logic [4:0]          WbRegNum;
   logic [31:0]         WbData;
   logic                wb_valid;
   logic                misalign;
   logic [TB_CNT_W-1:0] retire_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_stage #(.CNT_W(TB_CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .stall         (stall),
      .flush         (flush),
      .alu_res       (alu_res),
      .mem_rdata     (mem_rdata),
      .mem_addr_lo   (mem_addr_lo),
      .load_size     (load_size),
      .load_unsigned (load_unsigned),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .dst_reg       (dst_reg),
      .RegWrite      (RegWrite),
      .WbRegNum      (WbRegNum),
      .WbData        (WbData),
      .wb_valid      (wb_valid),
      .misalign      (misalign),
      .retire_cnt    (retire_cnt)
   );

   // Drive one entry's inputs (stimulus only, no checking).
   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                        input logic [1:0] lo, input logic [1:0] sz, input logic uns,
                        input logic m2r, input logic rw, input logic [4:0] dst);
      in_valid      = v;
      alu_res       = alu;
      mem_rdata     = rd;
      mem_addr_lo   = lo;
      load_size     = sz;
      load_unsigned = uns;
      mem_to_reg    = m2r;
      reg_write     = rw;
      dst_reg       = dst;
   endtask

   task automatic test_reset;
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({wb_valid, RegWrite, misalign, WbRegNum, WbData} !== 40'd0 || retire_cnt !== '0) begin
         bad++;
         $display("FAIL reset_state: got valid=%b rw=%b mis=%b reg=%0d data=%h cnt=%0d, want all 0",
                  wb_valid, RegWrite, misalign, WbRegNum, WbData, retire_cnt);
      end
      rst = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(posedge clk);
      @(negedge clk);
      $display("reset: valid=%b rw=%b", wb_valid, RegWrite);
   endtask

   task automatic test_alu;
      drive(1'b1, 32'h1234_5678, 32'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd5);
      @(posedge clk);
      #1;
      drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      total++;
      if (RegWrite !== 1'b1 || WbRegNum !== 5'd5 || WbData !== 32'h1234_5678 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL alu_write: got rw=%b reg=%0d data=%h rdy=%b, want rw=1 reg=5 data=12345678 rdy=1",
                  RegWrite, WbRegNum, WbData, in_ready);
      end
      $display("alu: rw=%b reg=%0d data=%h", RegWrite, WbRegNum, WbData);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b0 || RegWrite !== 1'b0) begin
         bad++;
         $display("FAIL alu_bubble: got valid=%b rw=%b, want 0 0", wb_valid, RegWrite);
      end
   endtask

   task automatic test_loads;
      logic [1:0]  lo_t  [6] = '{2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
      logic [1:0]  sz_t  [6] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd3};
      logic        un_t  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] exp_t [6] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                                 32'h0000_007F, 32'h0000_7F01, 32'h80FF_7F01};
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 32'hDEAD_BEEF, 32'h80FF_7F01, lo_t[i], sz_t[i], un_t[i], 1'b1, 1'b1, 5'(i + 10));
         @(posedge clk);
         #1;
         drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
         @(negedge clk);
         total++;
         if (WbData !== exp_t[i] || RegWrite !== 1'b1 || misalign !== 1'b0 || WbRegNum !== 5'(i + 10)) begin
            bad++;
            $display("FAIL load_%0d: got data=%h rw=%b mis=%b reg=%0d, want data=%h rw=1 mis=0 reg=%0d",
                     i, WbData, RegWrite, misalign, WbRegNum, exp_t[i], i + 10);
         end
         $display("load %0d: lo=%0d sz=%0d uns=%b data=%h", i, lo_t[i], sz_t[i], un_t[i], WbData);
      end
   endtask

   task automatic test_misalign;
      // half at odd offset
      drive(1'b1, 32'd0, 32'h80FF_7F01, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1, 5'd3);
      @(posedge clk);
      #1;
      drive(1'b1, 32'd0, 32'h80FF_7F01, 2'd2, 2'd2, 1'b0, 1'b1, 1'b1, 5'd4);
      @(negedge clk);
      total++;
      if (misalign !== 1'b1 || RegWrite !== 1'b0) begin
         bad++;
         $display("FAIL misalign_half: got mis=%b rw=%b, want mis=1 rw=0", misalign, RegWrite);
      end
      $display("misalign half: mis=%b rw=%b", misalign, RegWrite);
      // word at offset 2
      @(posedge clk);
      #1;
      drive(1'b1, 32'h0BAD_F00D, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd0);
      @(negedge clk);
      total++;
      if (misalign !== 1'b1 || RegWrite !== 1'b0) begin
         bad++;
         $display("FAIL misalign_word: got mis=%b rw=%b, want mis=1 rw=0", misalign, RegWrite);
      end
      $display("misalign word: mis=%b rw=%b", misalign, RegWrite);
      // valid ALU write to r0
      @(posedge clk);
      #1;
      drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      total++;
      if (RegWrite !== 1'b0 || wb_valid !== 1'b1 || misalign !== 1'b0) begin
         bad++;
         $display("FAIL zero_reg: got rw=%b valid=%b mis=%b, want rw=0 valid=1 mis=0",
                  RegWrite, wb_valid, misalign);
      end
      $display("zero reg: rw=%b valid=%b", RegWrite, wb_valid);
      @(posedge clk);
   endtask

   task automatic test_stall;
      int pulses = 0;
      drive(1'b1, 32'hAAAA_5555, 32'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd7);
      @(posedge clk);
      #1;
      stall = 1'b1;
      drive(1'b1, 32'h1111_2222, 32'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd9);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (RegWrite !== 1'b0 || in_ready !== 1'b0 || wb_valid !== 1'b1 ||
             WbRegNum !== 5'd7 || WbData !== 32'hAAAA_5555) begin
            bad++;
            $display("FAIL stall_hold_%0d: got rw=%b rdy=%b valid=%b reg=%0d data=%h, want 0 0 1 7 aaaa5555",
                     c, RegWrite, in_ready, wb_valid, WbRegNum, WbData);
         end
         $display("stall cycle %0d: rw=%b rdy=%b reg=%0d data=%h", c, RegWrite, in_ready, WbRegNum, WbData);
         if (c < 2) @(posedge clk);
      end
      stall = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      for (int c = 0; c < 3; c++) begin
         #1;
         if (RegWrite === 1'b1) pulses++;
         @(posedge clk);
         @(negedge clk);
      end
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL stall_release_pulses: got %0d RegWrite pulses, want 1", pulses);
      end
      $display("stall release: pulses=%0d", pulses);
   endtask

   task automatic test_flush;
      drive(1'b1, 32'h5A5A_5A5A, 32'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd8);
      @(posedge clk);
      #1;
      stall = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      stall = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b0 || RegWrite !== 1'b0) begin
         bad++;
         $display("FAIL flush_stall: got valid=%b rw=%b, want 0 0", wb_valid, RegWrite);
      end
      $display("flush+stall: valid=%b rw=%b", wb_valid, RegWrite);
      // flush with new valid input: flush wins
      drive(1'b1, 32'h0000_0042, 32'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd6);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b0 || RegWrite !== 1'b0) begin
         bad++;
         $display("FAIL flush_valid_in: got valid=%b rw=%b, want 0 0", wb_valid, RegWrite);
      end
      $display("flush+in_valid: valid=%b rw=%b", wb_valid, RegWrite);
   endtask

   task automatic test_rst_mid_stall;
      drive(1'b1, 32'hCAFE_0001, 32'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd12);
      @(posedge clk);
      #1;
      stall = 1'b1;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({wb_valid, RegWrite, misalign, WbRegNum, WbData} !== 40'd0 || retire_cnt !== '0) begin
         bad++;
         $display("FAIL rst_async: got valid=%b rw=%b mis=%b reg=%0d data=%h cnt=%0d, want all 0",
                  wb_valid, RegWrite, misalign, WbRegNum, WbData, retire_cnt);
      end
      $display("rst mid-stall: valid=%b reg=%0d data=%h", wb_valid, WbRegNum, WbData);
      @(negedge clk);
      rst = 1'b0;
      stall = 1'b0;
      drive(1'b1, 32'h0000_BEEF, 32'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd13);
      @(posedge clk);
      #1;
      drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      total++;
      if (RegWrite !== 1'b1 || WbRegNum !== 5'd13 || WbData !== 32'h0000_BEEF) begin
         bad++;
         $display("FAIL rst_recover: got rw=%b reg=%0d data=%h, want rw=1 reg=13 data=0000beef",
                  RegWrite, WbRegNum, WbData);
      end
      $display("after rst: rw=%b reg=%0d data=%h", RegWrite, WbRegNum, WbData);
      @(posedge clk);
   endtask

   task automatic test_retire;
      logic [TB_CNT_W-1:0] want;
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      // 17 fired entries: mix of write, no-write and misaligned
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 32'(i), 32'd0, 2'(i), 2'd2, 1'b0, 1'(i % 3 == 0), 1'(i % 2), 5'd1);
         @(posedge clk);
         #1;
      end
      drive(1'b0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(posedge clk);
      @(negedge clk);
`ifdef WB_RETIRE_CNT_EN
      want = TB_CNT_W'(1);
`else
      want = '0;
`endif
      total++;
      if (retire_cnt !== want) begin
         bad++;
         $display("FAIL retire_cnt: got %0d, want %0d", retire_cnt, want);
      end
      $display("retire: cnt=%0d", retire_cnt);
   endtask

   initial begin
      test_reset;
      test_alu;
      test_loads;
      test_misalign;
      test_stall;
      test_flush;
      test_rst_mid_stall;
      test_retire;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of retire counter.
REQ-002 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1 (MEM result valid) and in_ready output 1 (stage accepts).
REQ-005 SHALL have ports stall input 1 (hold stage) and flush input 1 (kill held entry).
REQ-006 SHALL have ports alu_res input 32 and mem_rdata input 32 (raw memory word).
REQ-007 SHALL have ports mem_addr_lo input 2 (byte offset), load_size input 2 (00 byte, 01 half, 10/11 word), load_unsigned input 1.
REQ-008 SHALL have ports mem_to_reg input 1, reg_write input 1, dst_reg input 5.
REQ-009 SHALL have ports RegWrite output 1, WbRegNum output 5, WbData output 32 (regfile write port, regfile samples on negedge).
REQ-010 SHALL have ports wb_valid output 1, misalign output 1, retire_cnt output CNT_W.

Function
REQ-011 SHALL drive in_ready = !stall, combinationally.
REQ-012 SHALL capture all inputs into one pipeline register on posedge when !stall && !flush; wb_valid takes in_valid.
REQ-013 SHALL hold register contents and wb_valid unchanged while stall=1 && flush=0.
REQ-014 SHALL clear wb_valid on posedge when flush=1, regardless of stall or in_valid (flush wins).
REQ-015 SHALL define fire = wb_valid && !stall, combinational.
REQ-016 SHALL drive RegWrite = fire && reg_write_q && WbRegNum!=0 && !misalign.
REQ-017 SHALL drive WbRegNum = dst_reg_q at all times; WbData = alu_res_q when mem_to_reg_q=0, else aligned load data.
REQ-018 SHALL align loads little-endian: byte = mem_rdata[8*addr_lo+:8]; half = mem_rdata[16*addr_lo[1]+:16]; word = mem_rdata.
REQ-019 SHALL sign-extend byte/half when load_unsigned_q=0, zero-extend when 1.
REQ-020 SHALL assert misalign = fire && mem_to_reg_q && ((half && addr_lo[0]) || (word && addr_lo!=0)); write suppressed that cycle.
REQ-021 SHALL give latency one cycle: input accepted at edge N appears on RegWrite/WbData during cycle N+1, written at that cycle's negedge.
REQ-022 SHALL emit RegWrite at most once per accepted entry (no repeat writes while stalled).

Reset
REQ-023 SHALL on rst force wb_valid=0, RegWrite=0, misalign=0, WbRegNum=0, WbData=0, retire_cnt=0 immediately, independent of clk.
REQ-024 SHALL on rst mid-stall discard the held entry; first posedge after release captures normally.

Configuration
REQ-025 SHALL honour macro WB_RETIRE_CNT_EN: when defined, retire_cnt increments by 1 on each posedge with fire=1 (including misaligned and no-write instructions), wrapping all-ones to 0.
REQ-026 SHALL when WB_RETIRE_CNT_EN is undefined keep the retire_cnt port, tied to 0, with no counter flops.

Structure
REQ-027 SHALL place load-size encodings (LS_BYTE, LS_HALF, LS_WORD) and ZERO_REG constant in shared package wb_pkg.
REQ-028 SHALL implement extraction/extension (REQ-018/019) in combinational sub-module load_align.

Verification
REQ-029 SHALL cover: alu_res=0x12345678, dst=5, reg_write=1, mem_to_reg=0 -> next cycle RegWrite=1, WbRegNum=5, WbData=0x12345678.
REQ-030 SHALL cover: mem_rdata=0x80FF7F01, byte load addr_lo=2 signed -> WbData=0xFFFFFFFF; addr_lo=3 unsigned -> 0x00000080; half addr_lo=2 signed -> 0xFFFF80FF.
REQ-031 SHALL cover: half load addr_lo=1 -> misalign=1, RegWrite=0; dst=0 valid write -> RegWrite=0.
REQ-032 SHALL cover: stall held 3 cycles with valid entry -> outputs stable, RegWrite=0, in_ready=0; stall release -> single RegWrite pulse.
REQ-033 SHALL cover: flush and stall together -> wb_valid=0 next cycle; rst asserted mid-stall -> all outputs 0 asynchronously.
REQ-034 SHALL cover (WB_RETIRE_CNT_EN, CNT_W=4): 17 fired entries -> retire_cnt=1 after wrap.
